status_flag_unit: RTL and testbench

//  - Producer side of the N/Z/C/V status interface. Computes flags from the EXE-stage ALU result and

---
 rtl/status_flag_unit_pkg.sv | 20 ++
 rtl/status_flag_unit_if.sv | 31 +++
 rtl/status_flag_unit_gen.sv | 39 +++
 rtl/status_flag_unit.sv | 73 +++++++
 tb/tb_status_flag_unit.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/status_flag_unit_pkg.sv
// Shared status-flag definitions: register width, flag bit positions, op classes.
package status_flag_unit_pkg;

    localparam int unsigned STATUS_REG_LEN = 4;

    localparam int unsigned Z_IDX = 3;
    localparam int unsigned C_IDX = 2;
    localparam int unsigned N_IDX = 1;
    localparam int unsigned V_IDX = 0;

    typedef enum logic [1:0] {
        OPC_LOGIC = 2'b00,
        OPC_ADD   = 2'b01,
        OPC_SUB   = 2'b10,
        OPC_NONE  = 2'b11
    } opc_e;

    typedef logic [STATUS_REG_LEN-1:0] stat_t;

endpackage

// File: rtl/status_flag_unit_if.sv
// EXE/ID <-> status flag unit interface. master = pipeline side, slave = flag unit.
interface status_flag_unit_if
    import status_flag_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAT_W = STATUS_REG_LEN
);
    logic              alu_valid;
    logic              s_bit;
    opc_e              op_class;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              op_a_msb;
    logic              op_b_msb;
    logic              stall;
    logic              flush;
    logic [STAT_W-1:0] stat_reg;
    logic              flags_hazard;

    modport master (
        output alu_valid, s_bit, op_class, alu_result, alu_carry,
               op_a_msb, op_b_msb, stall, flush,
        input  stat_reg, flags_hazard
    );

    modport slave (
        input  alu_valid, s_bit, op_class, alu_result, alu_carry,
               op_a_msb, op_b_msb, stall, flush,
        output stat_reg, flags_hazard
    );
endinterface

// File: rtl/status_flag_unit_gen.sv
// status_flag_gen: combinational {Z,C,N,V} generation from the EXE-stage ALU result.
module status_flag_gen
    import status_flag_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] result_i,
    input  logic              carry_i,
    input  logic              a_msb_i,
    input  logic              b_msb_i,
    input  opc_e              op_class_i,
    input  logic              prev_c_i,
    input  logic              prev_v_i,
    output stat_t             flags_o
);
    logic r_msb;
    assign r_msb = result_i[DATA_W-1];

    // Z/N always from the result; C/V from the ALU for arithmetic, carried over for logic ops
    always_comb begin
        flags_o        = '0;
        flags_o[Z_IDX] = (result_i == '0);
        flags_o[N_IDX] = r_msb;
        unique case (op_class_i)
            OPC_ADD: begin
                flags_o[C_IDX] = carry_i;
                flags_o[V_IDX] = (a_msb_i == b_msb_i) & (r_msb != a_msb_i);
            end
            OPC_SUB: begin
                flags_o[C_IDX] = carry_i;
                flags_o[V_IDX] = (a_msb_i != b_msb_i) & (r_msb != a_msb_i);
            end
            default: begin
                flags_o[C_IDX] = prev_c_i;
                flags_o[V_IDX] = prev_v_i;
            end
        endcase
    end
endmodule

// File: rtl/status_flag_unit.sv
// status_flag_unit: capture (EXE) / commit pipeline for the architectural N/Z/C/V status.
// Optional macro STATUS_BYPASS_EN forwards pending flags to stat_reg and ties flags_hazard low.
module status_flag_unit
    import status_flag_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAT_W = STATUS_REG_LEN
) (
    input logic               clk,
    input logic               rst_n,
    status_flag_unit_if.slave bus
);
    logic [STAT_W-1:0] status_q, status_d;
    logic [STAT_W-1:0] pend_flags_q, pend_flags_d;
    logic              pend_valid_q, pend_valid_d;
    logic [STAT_W-1:0] newest;
    stat_t             new_flags;
    logic              cap;

    // LOGIC ops inherit C/V from the newest flags, which may still be pending
    assign newest = pend_valid_q ? pend_flags_q : status_q;

    assign cap = bus.alu_valid & bus.s_bit & (bus.op_class != OPC_NONE)
               & ~bus.stall & ~bus.flush;

    status_flag_gen #(
        .DATA_W (DATA_W)
    ) u_gen (
        .result_i   (bus.alu_result),
        .carry_i    (bus.alu_carry),
        .a_msb_i    (bus.op_a_msb),
        .b_msb_i    (bus.op_b_msb),
        .op_class_i (bus.op_class),
        .prev_c_i   (newest[C_IDX]),
        .prev_v_i   (newest[V_IDX]),
        .flags_o    (new_flags)
    );

    // Next state: commit old pending and capture new on the same edge; flush squashes the commit
    always_comb begin
        pend_valid_d = cap;
        pend_flags_d = pend_flags_q;
        status_d     = status_q;
        if (cap) begin
            pend_flags_d = new_flags;
        end
        if (pend_valid_q && !bus.flush) begin
            status_d = pend_flags_q;
        end
    end

    // Pending and architectural status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q     <= '0;
            pend_flags_q <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            status_q     <= status_d;
            pend_flags_q <= pend_flags_d;
            pend_valid_q <= pend_valid_d;
        end
    end

`ifdef STATUS_BYPASS_EN
    assign bus.stat_reg     = newest;
    assign bus.flags_hazard = 1'b0;
`else
    assign bus.stat_reg     = status_q;
    assign bus.flags_hazard = pend_valid_q;
`endif

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed self-checking bench for status_flag_unit (default build and STATUS_BYPASS_EN build).
module tb_status_flag_unit;
    import status_flag_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    status_flag_unit_if #(.DATA_W(32), .STAT_W(4)) bus ();

    status_flag_unit #(.DATA_W(32), .STAT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid  = 1'b0;
        bus.s_bit      = 1'b0;
        bus.op_class   = OPC_NONE;
        bus.alu_result = '0;
        bus.alu_carry  = 1'b0;
        bus.op_a_msb   = 1'b0;
        bus.op_b_msb   = 1'b0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic drive_op(input opc_e opc, input logic [31:0] r, input logic c,
                            input logic a, input logic b);
        bus.alu_valid  = 1'b1;
        bus.s_bit      = 1'b1;
        bus.op_class   = opc;
        bus.alu_result = r;
        bus.alu_carry  = c;
        bus.op_a_msb   = a;
        bus.op_b_msb   = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        step();
        step();
        checks++;
        if (bus.stat_reg !== 4'b0000) begin
            errors++; $display("FAIL reset_stat: got %b want %b", bus.stat_reg, 4'b0000);
        end
        checks++;
        if (bus.flags_hazard !== 1'b0) begin
            errors++; $display("FAIL reset_hazard: got %b want %b", bus.flags_hazard, 1'b0);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_zero_carry();
        drive_op(OPC_ADD, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        checks++;
        if (bus.flags_hazard !== 1'b1) begin
            errors++; $display("FAIL t1_hazard_k: got %b want %b", bus.flags_hazard, 1'b1);
        end
        checks++;
        if (bus.stat_reg !== 4'b0000) begin
            errors++; $display("FAIL t1_stat_k: got %b want %b", bus.stat_reg, 4'b0000);
        end
        step();
        checks++;
        if (bus.stat_reg !== 4'b1100) begin
            errors++; $display("FAIL t1_stat_k1: got %b want %b", bus.stat_reg, 4'b1100);
        end
        checks++;
        if (bus.flags_hazard !== 1'b0) begin
            errors++; $display("FAIL t1_hazard_k1: got %b want %b", bus.flags_hazard, 1'b0);
        end
    endtask

    task automatic test_add_overflow();
        drive_op(OPC_ADD, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        step();
        checks++;
        if (bus.stat_reg !== 4'b0011) begin
            errors++; $display("FAIL t2_add_ovf: got %b want %b", bus.stat_reg, 4'b0011);
        end
    endtask

    task automatic test_logic_preserve();
        drive_op(OPC_ADD, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        step();
        drive_op(OPC_LOGIC, 32'h5, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        step();
        checks++;
        if (bus.stat_reg !== 4'b0100) begin
            errors++; $display("FAIL t3_logic: got %b want %b", bus.stat_reg, 4'b0100);
        end
    endtask

    task automatic test_flush();
        drive_op(OPC_ADD, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        bus.flush = 1'b1;
        checks++;
        if (bus.flags_hazard !== 1'b1) begin
            errors++; $display("FAIL t4_hazard_pre: got %b want %b", bus.flags_hazard, 1'b1);
        end
        step();
        bus.flush = 1'b0;
        checks++;
        if (bus.stat_reg !== 4'b0100) begin
            errors++; $display("FAIL t4_stat_held: got %b want %b", bus.stat_reg, 4'b0100);
        end
        checks++;
        if (bus.flags_hazard !== 1'b0) begin
            errors++; $display("FAIL t4_hazard_post: got %b want %b", bus.flags_hazard, 1'b0);
        end
        // flush in the capture cycle blocks the capture itself
        drive_op(OPC_ADD, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        bus.flush = 1'b1;
        step();
        idle();
        checks++;
        if (bus.flags_hazard !== 1'b0) begin
            errors++; $display("FAIL t4_flush_cap: got %b want %b", bus.flags_hazard, 1'b0);
        end
        step();
        checks++;
        if (bus.stat_reg !== 4'b0100) begin
            errors++; $display("FAIL t4_flush_cap_stat: got %b want %b", bus.stat_reg, 4'b0100);
        end
    endtask

    task automatic test_back_to_back();
        drive_op(OPC_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        step();
        drive_op(OPC_LOGIC, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.stat_reg !== 4'b0100) begin
            errors++; $display("FAIL t5_stat_k: got %b want %b", bus.stat_reg, 4'b0100);
        end
        step();
        idle();
        checks++;
        if (bus.stat_reg !== 4'b0101) begin
            errors++; $display("FAIL t5_stat_sub: got %b want %b", bus.stat_reg, 4'b0101);
        end
        checks++;
        if (bus.flags_hazard !== 1'b1) begin
            errors++; $display("FAIL t5_hazard: got %b want %b", bus.flags_hazard, 1'b1);
        end
        step();
        checks++;
        if (bus.stat_reg !== 4'b1101) begin
            errors++; $display("FAIL t5_stat_logic: got %b want %b", bus.stat_reg, 4'b1101);
        end
    endtask

    task automatic test_no_capture(input logic [3:0] held);
        drive_op(OPC_ADD, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.stall = 1'b1;
        step();
        idle();
        checks++;
        if (bus.flags_hazard !== 1'b0) begin
            errors++; $display("FAIL nc_stall_hazard: got %b want %b", bus.flags_hazard, 1'b0);
        end
        drive_op(OPC_NONE, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        drive_op(OPC_ADD, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.s_bit = 1'b0;
        step();
        drive_op(OPC_ADD, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.alu_valid = 1'b0;
        step();
        idle();
        checks++;
        if (bus.flags_hazard !== 1'b0) begin
            errors++; $display("FAIL nc_hazard: got %b want %b", bus.flags_hazard, 1'b0);
        end
        step();
        checks++;
        if (bus.stat_reg !== held) begin
            errors++; $display("FAIL nc_stat: got %b want %b", bus.stat_reg, held);
        end
    endtask

    task automatic test_stall_commit();
        drive_op(OPC_ADD, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        drive_op(OPC_ADD, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        bus.stall = 1'b1;
        step();
        idle();
        checks++;
        if (bus.stat_reg !== 4'b1000) begin
            errors++; $display("FAIL stall_commit: got %b want %b", bus.stat_reg, 4'b1000);
        end
        checks++;
        if (bus.flags_hazard !== 1'b0) begin
            errors++; $display("FAIL stall_hazard: got %b want %b", bus.flags_hazard, 1'b0);
        end
    endtask

    task automatic test_mid_reset();
        drive_op(OPC_ADD, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.stat_reg !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_stat: got %b want %b", bus.stat_reg, 4'b0000);
        end
        checks++;
        if (bus.flags_hazard !== 1'b0) begin
            errors++; $display("FAIL mid_reset_hazard: got %b want %b", bus.flags_hazard, 1'b0);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.stat_reg !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_partial: got %b want %b", bus.stat_reg, 4'b0000);
        end
    endtask

    task automatic test_bypass();
        drive_op(OPC_ADD, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        checks++;
        if (bus.stat_reg !== 4'b0011) begin
            errors++; $display("FAIL byp_stat_k: got %b want %b", bus.stat_reg, 4'b0011);
        end
        checks++;
        if (bus.flags_hazard !== 1'b0) begin
            errors++; $display("FAIL byp_hazard_k: got %b want %b", bus.flags_hazard, 1'b0);
        end
        step();
        checks++;
        if (bus.stat_reg !== 4'b0011) begin
            errors++; $display("FAIL byp_stat_k1: got %b want %b", bus.stat_reg, 4'b0011);
        end
        drive_op(OPC_ADD, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        bus.flush = 1'b1;
        checks++;
        if (bus.stat_reg !== 4'b1100) begin
            errors++; $display("FAIL byp_fwd: got %b want %b", bus.stat_reg, 4'b1100);
        end
        step();
        bus.flush = 1'b0;
        checks++;
        if (bus.stat_reg !== 4'b0011) begin
            errors++; $display("FAIL byp_flush: got %b want %b", bus.stat_reg, 4'b0011);
        end
        checks++;
        if (bus.flags_hazard !== 1'b0) begin
            errors++; $display("FAIL byp_flush_hazard: got %b want %b", bus.flags_hazard, 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        test_reset();
`ifdef STATUS_BYPASS_EN
        test_bypass();
        test_no_capture(4'b0011);
        test_mid_reset();
`else
        test_add_zero_carry();
        test_add_overflow();
        test_logic_preserve();
        test_flush();
        test_back_to_back();
        test_no_capture(4'b1101);
        test_stall_commit();
        test_mid_reset();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
